upcnt_mod: RTL
==============

UPCNT_MOD -- requirements
Module: upcnt_mod

Interface
REQ-001 Parameter: WIDTH, default 16, counter width in bits (legal 2..32).
REQ-002 Parameter: MAX, default 2^WIDTH-1, terminal count; the counter range is 0..MAX (legal 1..2^WIDTH-1).
REQ-003 Parameter: RESET_VAL, default 0, value q takes on reset (legal 0..MAX).
REQ-004 Port sys_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port d  input  WIDTH  load value.
REQ-007 Port ld  input  1  synchronous load request.
REQ-008 Port ci  input  1  count enable and carry-in for chaining.
REQ-009 Port dn  input  1  direction: 0 counts up, 1 counts down.
REQ-010 Port cmp  input  WIDTH  compare value.
REQ-011 Port ovf_clr  input  1  synchronous clear of sticky ovf.
REQ-012 Port q  output  WIDTH  registered count.
REQ-013 Port co  output  1  combinational carry-out for chaining.
REQ-014 Port tc  output  1  registered one-cycle wrap pulse.
REQ-015 Port match  output  1  registered q==cmp flag.
REQ-016 Port ovf  output  1  sticky wrap flag.

Function
REQ-017 Priority per edge SHALL be: ld, then count (ci=1), then hold.
REQ-018 Load: q SHALL become d if d<=MAX, else MAX (clamped); direction and ci SHALL be ignored.
REQ-019 Up count (ci=1, dn=0, ld=0): q SHALL become q+1 if q<MAX, else 0.
REQ-020 Down count (ci=1, dn=1, ld=0): q SHALL become q-1 if q>0, else MAX.
REQ-021 Hold (ci=0, ld=0): q SHALL be unchanged.
REQ-022 co SHALL equal ci & ~ld & (dn ? q==0 : q==MAX), with zero latency, so chained stages advance on the same edge.
REQ-023 tc SHALL be 1 for exactly the cycle after an edge on which a wrap occurred (up MAX->0 or down 0->MAX); loads SHALL never raise tc.
REQ-024 match SHALL reflect (q==cmp) evaluated on the updated q, registered, so it is valid in the same cycle q shows the new value; a change of cmp alone SHALL show on match one edge later.
REQ-025 ovf SHALL set on any wrap edge and stay 1 until an edge with ovf_clr=1 and no wrap.
REQ-026 Simultaneous wrap and ovf_clr: set SHALL win; ovf=1.
REQ-027 Load of a value equal to cmp SHALL raise match on the following cycle, same as counting.
REQ-028 MAX=2^WIDTH-1 SHALL behave as natural binary wrap; no arithmetic result SHALL exceed WIDTH bits internally visible on q.
REQ-029 Outputs SHALL carry no X after reset for any input values, including X on d when ld=0.

Reset
REQ-030 reset=1 SHALL immediately (asynchronously) force q=RESET_VAL, tc=0, ovf=0, match=0, independent of sys_clk.
REQ-031 co SHALL follow REQ-022 during reset using q=RESET_VAL.
REQ-032 Deassertion SHALL be synchronous in effect: the first count or load SHALL occur on the first rising edge with reset=0.
REQ-033 Reset asserted mid-count or mid-load SHALL discard the in-flight update; no tc or ovf SHALL be produced by that edge.

Verification (WIDTH=4, MAX=9, RESET_VAL=0 unless stated)
REQ-034 Up wrap: reset, ci=1, dn=0 for 10 edges -> q steps 1..9 then 0; tc=1 only in the cycle q=0; ovf=1 afterwards; co=1 only while q=9.
REQ-035 Down wrap and clamp: ld=1, d=15 -> q=9; then ld=0, ci=1, dn=1 for 10 edges -> q steps 8..0 then 9; tc pulses once at q=9.
REQ-036 Load priority: q=9, ld=1, ci=1, d=3 -> q=3, tc=0, co=0 during that cycle; cmp=3 -> match=1 in the same cycle q=3.
REQ-037 Sticky clear race: ovf=1, q=9 counting up with ovf_clr=1 -> ovf stays 1; next edge with ovf_clr=1, no wrap -> ovf=0.
REQ-038 Async reset: while counting at q=5, pulse reset between edges -> q=0, tc=0, ovf=0 before the next edge; counting resumes at 1 on the first edge after release.
REQ-039 Chaining: two instances, second ci=first co, WIDTH=4, MAX=9 -> 100 up edges give {q2,q1} sequence 00..99 then 00, with a single tc on the second stage at the rollover.

Source files
------------

// File: rtl/upcnt_mod.sv
// Bounded up/down counter (0..MAX) with load clamp, chainable carry-out,
// registered wrap pulse, registered compare flag and a sticky wrap flag.
module upcnt_mod #(
  parameter int unsigned     WIDTH     = 16,
  parameter longint unsigned MAX       = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  input  logic             ci,
  input  logic             dn,
  input  logic [WIDTH-1:0] cmp,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             tc,
  output logic             match,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, match_q, match_d, ovf_q, ovf_d;
  logic             at_min, at_max, wrap;

  always_comb begin
    at_min = (q_q == '0);
    at_max = (q_q == MAX_V);
    wrap   = ci & ~ld & (dn ? at_min : at_max);

    // Load is checked first so d (possibly unknown) is never sampled when ld=0.
    q_d = q_q;
    if (ld) begin
      q_d = (d > MAX_V) ? MAX_V : d;
    end else if (ci) begin
      if (dn) begin
        q_d = at_min ? MAX_V : q_q - 1'b1;
      end else begin
        q_d = at_max ? '0 : q_q + 1'b1;
      end
    end

    // Compare against the post-edge count so match lines up with the new q.
    match_d = (q_d == cmp);
    ovf_d   = wrap | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      q_q     <= RST_V;
      tc_q    <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      tc_q    <= wrap;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q     = q_q;
  assign co    = wrap;
  assign tc    = tc_q;
  assign match = match_q;
  assign ovf   = ovf_q;

endmodule
